bp_cfg_bus_loader: RTL and testbench
====================================

# bp_cfg_bus_loader

Runtime configuration sequencer for multicore BlackParrot systems. On a start pulse, it walks a parametrised table of (address, data) entries and writes each entry over the config bus to every core selected by a mask. An optional verify mode reads each register back and compares it. The block sits between the host/boot controller and the per-tile config-bus endpoints, replacing hand-sequenced config writes.

## Interface
- num_core_p, 1: number of addressable cores.
- num_entries_p, 8: table entries written per core; must be ≥1.
- cfg_core_width_p, 8: config-bus core-id width; must be ≥ clog2(num_core_p).
- cfg_addr_width_p, 16: config-bus address width.
- cfg_data_width_p, 64: config-bus data width.

- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- start_i  in  1  start pulse; honoured only when idle.
- verify_i  in  1  sampled at start; 1 = write then read-back compare per entry.
- core_mask_i  in  num_core_p  target cores; sampled at start.
- table_addr_i  in  num_entries_p*cfg_addr_width_p  entry addresses; entry k in bits [k*W +: W]; must be held stable while busy.
- table_data_i  in  num_entries_p*cfg_data_width_p  entry data; same packing and stability rule.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse at sequence end.
- err_o  out  1  sticky readback mismatch; cleared on accepted start.
- err_cnt_o  out  8  mismatch count, saturating at 255; cleared on accepted start.
- cfg_v_o  out  1  config request valid.
- cfg_w_v_o  out  1  1 = write, 0 = read.
- cfg_core_o  out  cfg_core_width_p  target core id.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  write data; 0 on reads.
- cfg_ready_i  in  1  endpoint accepts request.
- cfg_resp_v_i  in  1  read response valid.
- cfg_resp_data_i  in  cfg_data_width_p  read response data.

## Operation
- Reset values: all outputs 0; FSM in e_idle; counters 0.
- States: e_idle, e_write, e_read, e_resp, e_done.
- e_idle:
  - start_i=1 latches mask and verify, and clears err_o and err_cnt_o.
  - If the mask is empty, go to e_done.
  - Otherwise go to e_write with core = lowest set mask bit and entry = 0.
- e_write: cfg_v_o=1, cfg_w_v_o=1, address and data from the current entry.
  - On handshake with verify=1: go to e_read.
  - On handshake with verify=0: advance, then stay in e_write or go to e_done.
- e_read: cfg_v_o=1, cfg_w_v_o=0, same address. On handshake, go to e_resp.
- e_resp: waits for cfg_resp_v_i.
  - Compare response data with the table data. On mismatch, set err_o and increment err_cnt_o (saturating).
  - Then advance.
- Advance:
  - If the entry is not the last, entry+1.
  - Otherwise entry=0 and core = next higher set mask bit.
  - If no set bit remains, go to e_done.
- e_done: done_o=1 for one cycle, then e_idle.
- Handshake: a request fires when cfg_v_o & cfg_ready_i. Once cfg_v_o is asserted, it and the payload stay stable until the handshake; no retraction.
- cfg_resp_v_i outside e_resp is ignored.
- start_i while busy is ignored; mask, verify and table changes during busy have no effect on latched state.
- busy_o=1 in every state except e_idle.
- Reset mid-sequence:
  - Immediate return to e_idle with all outputs 0.
  - Any in-flight request is abandoned.
  - err state is cleared.

## Timing
- start at cycle 0 → first cfg_v_o at cycle 1.
- Write-only mode with ready tied high: one write per cycle, no bubbles between entries or across skipped mask bits.
  - Total cycles from start to done_o = cores_selected*num_entries_p + 1.
- Verify mode: at least 3 cycles per entry (write, read, response). A response is accepted no earlier than the cycle after the read handshake.
- done_o asserts the cycle after the final handshake or response.
- Empty mask: done_o at cycle 1.
- err_o and err_cnt_o update the cycle after the mismatching response.

## Structure
- bp_common_cfg_loader_pkg holds:
  - the state enum bp_cfg_loader_state_e;
  - a packed struct bp_cfg_bus_req_s with fields w_v, core, addr and data, parametrised via a define macro.
- Next-core selection uses bsg_priority_encode on (mask & ~((1<<(core+1))-1)), one instance.
- The entry counter and core register live in the top; no other sub-modules.

## Test plan
- Write-only with num_core_p=4, mask=4'b1010, num_entries_p=2, ready high:
  - writes in order (core1,e0), (core1,e1), (core3,e0), (core3,e1) on cycles 1–4;
  - done_o on cycle 5.
- Backpressure: ready low for 3 cycles mid-sequence → payload is held stable, no duplicate or skipped entry.
- Verify mode with core0 returning table data except entry1 XOR 1:
  - err_o=1, err_cnt_o=1;
  - a new start clears both.
- Empty mask → busy_o for one cycle, done_o at cycle 1, no cfg_v_o.
- Stray response in e_write, and start_i pulsed mid-sequence → both ignored, sequence unchanged.
- reset_n_i asserted during e_resp → all outputs 0 immediately; a subsequent start runs a full sequence correctly.

Source files
------------

// File: rtl/bp_cfg_bus_loader_pkg.sv
// Shared types for the config-bus loader: sequencer states, the request
// struct macro, and a saturating increment for the mismatch counter.

`ifndef BP_CFG_BUS_LOADER_PKG_SV
`define BP_CFG_BUS_LOADER_PKG_SV

`define DECLARE_BP_CFG_BUS_REQ_S(core_width_mp, addr_width_mp, data_width_mp) \
    typedef struct packed {                                                  \
        logic                     w_v;                                       \
        logic [core_width_mp-1:0] core;                                      \
        logic [addr_width_mp-1:0] addr;                                      \
        logic [data_width_mp-1:0] data;                                      \
    } bp_cfg_bus_req_s

package bp_common_cfg_loader_pkg;

    typedef enum logic [2:0] {
        e_idle,
        e_write,
        e_read,
        e_resp,
        e_done
    } bp_cfg_loader_state_e;

    localparam int err_cnt_width_gp = 8;

    function automatic logic [err_cnt_width_gp-1:0] sat_inc8(input logic [err_cnt_width_gp-1:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

endpackage

`endif

// File: rtl/bp_cfg_bus_loader_prio.sv
// Priority encoder: returns the index of the lowest (or highest) set bit
// and a valid flag when any bit is set.

module bsg_priority_encode #(
    parameter int width_p    = 4,
    parameter int lo_to_hi_p = 1,
    localparam int addr_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic [width_p-1:0]       i,
    output logic [addr_width_lp-1:0] addr_o,
    output logic                     v_o
);

    // Scan so that the winning bit is the last one written.
    always_comb begin
        addr_o = '0;
        v_o    = |i;
        if (lo_to_hi_p != 0) begin
            for (int k = width_p - 1; k >= 0; k--) begin
                if (i[k]) addr_o = addr_width_lp'(k);
            end
        end else begin
            for (int k = 0; k < width_p; k++) begin
                if (i[k]) addr_o = addr_width_lp'(k);
            end
        end
    end

endmodule

// File: rtl/bp_cfg_bus_loader.sv
// Config-bus loader: on start, writes every table entry to every selected
// core, optionally reading each register back and counting mismatches.

module bp_cfg_bus_loader
    import bp_common_cfg_loader_pkg::*;
#(
    parameter int num_core_p       = 1,
    parameter int num_entries_p    = 8,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic                                       start_i,
    input  logic                                       verify_i,
    input  logic [num_core_p-1:0]                      core_mask_i,
    input  logic [num_entries_p*cfg_addr_width_p-1:0]  table_addr_i,
    input  logic [num_entries_p*cfg_data_width_p-1:0]  table_data_i,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       err_o,
    output logic [7:0]                                 err_cnt_o,
    output logic                                       cfg_v_o,
    output logic                                       cfg_w_v_o,
    output logic [cfg_core_width_p-1:0]                cfg_core_o,
    output logic [cfg_addr_width_p-1:0]                cfg_addr_o,
    output logic [cfg_data_width_p-1:0]                cfg_data_o,
    input  logic                                       cfg_ready_i,
    input  logic                                       cfg_resp_v_i,
    input  logic [cfg_data_width_p-1:0]                cfg_resp_data_i
);

    localparam int entry_width_lp = (num_entries_p > 1) ? $clog2(num_entries_p) : 1;
    localparam int enc_width_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    `DECLARE_BP_CFG_BUS_REQ_S(cfg_core_width_p, cfg_addr_width_p, cfg_data_width_p);

    bp_cfg_loader_state_e          state_r;
    bp_cfg_bus_req_s               req_r, wr_req;
    logic [num_core_p-1:0]         mask_r, higher_mask, enc_in;
    logic                          verify_r, cfg_v_r, busy_r, done_r, err_r;
    logic [7:0]                    err_cnt_r;
    logic [entry_width_lp-1:0]     entry_r, nxt_entry, load_entry;
    logic [cfg_core_width_p-1:0]   core_r, nxt_core, load_core;
    logic [enc_width_lp-1:0]       enc_addr;
    logic                          enc_v, last_entry, adv_v, mismatch;
    logic [cfg_data_width_p-1:0]   exp_data;

    // In idle the encoder finds the first core of the incoming mask;
    // otherwise it finds the next selected core above the current one.
    always_comb begin
        higher_mask = '0;
        for (int k = 0; k < num_core_p; k++) begin
            higher_mask[k] = (k > int'(core_r));
        end
        enc_in = (state_r == e_idle) ? core_mask_i : (mask_r & higher_mask);
    end

    bsg_priority_encode #(
        .width_p    (num_core_p),
        .lo_to_hi_p (1)
    ) next_core_enc (
        .i      (enc_in),
        .addr_o (enc_addr),
        .v_o    (enc_v)
    );

    // Advance bookkeeping and the write request for the entry about to be loaded.
    always_comb begin
        last_entry = (entry_r == entry_width_lp'(num_entries_p - 1));
        adv_v      = !last_entry || enc_v;
        nxt_entry  = last_entry ? '0 : entry_r + entry_width_lp'(1);
        nxt_core   = last_entry ? cfg_core_width_p'(enc_addr) : core_r;
        load_entry = (state_r == e_idle) ? '0 : nxt_entry;
        load_core  = (state_r == e_idle) ? cfg_core_width_p'(enc_addr) : nxt_core;
        wr_req.w_v  = 1'b1;
        wr_req.core = load_core;
        wr_req.addr = table_addr_i[int'(load_entry)*cfg_addr_width_p +: cfg_addr_width_p];
        wr_req.data = table_data_i[int'(load_entry)*cfg_data_width_p +: cfg_data_width_p];
        exp_data    = table_data_i[int'(entry_r)*cfg_data_width_p +: cfg_data_width_p];
        mismatch    = (cfg_resp_data_i != exp_data);
    end

    // Sequencer with registered bus request and status outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_idle;
            req_r     <= '0;
            mask_r    <= '0;
            verify_r  <= 1'b0;
            cfg_v_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= '0;
            entry_r   <= '0;
            core_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                e_idle: begin
                    if (start_i) begin
                        mask_r    <= core_mask_i;
                        verify_r  <= verify_i;
                        err_r     <= 1'b0;
                        err_cnt_r <= '0;
                        busy_r    <= 1'b1;
                        entry_r   <= '0;
                        if (enc_v) begin
                            core_r  <= load_core;
                            req_r   <= wr_req;
                            cfg_v_r <= 1'b1;
                            state_r <= e_write;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= e_done;
                        end
                    end
                end
                e_write: begin
                    if (cfg_ready_i) begin
                        if (verify_r) begin
                            req_r.w_v  <= 1'b0;
                            req_r.data <= '0;
                            state_r    <= e_read;
                        end else if (adv_v) begin
                            entry_r <= nxt_entry;
                            core_r  <= nxt_core;
                            req_r   <= wr_req;
                        end else begin
                            entry_r <= '0;
                            cfg_v_r <= 1'b0;
                            req_r   <= '0;
                            done_r  <= 1'b1;
                            state_r <= e_done;
                        end
                    end
                end
                e_read: begin
                    if (cfg_ready_i) begin
                        cfg_v_r <= 1'b0;
                        req_r   <= '0;
                        state_r <= e_resp;
                    end
                end
                e_resp: begin
                    if (cfg_resp_v_i) begin
                        if (mismatch) begin
                            err_r     <= 1'b1;
                            err_cnt_r <= sat_inc8(err_cnt_r);
                        end
                        if (adv_v) begin
                            entry_r <= nxt_entry;
                            core_r  <= nxt_core;
                            req_r   <= wr_req;
                            cfg_v_r <= 1'b1;
                            state_r <= e_write;
                        end else begin
                            entry_r <= '0;
                            done_r  <= 1'b1;
                            state_r <= e_done;
                        end
                    end
                end
                e_done: begin
                    busy_r  <= 1'b0;
                    state_r <= e_idle;
                end
                default: state_r <= e_idle;
            endcase
        end
    end

    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign err_o      = err_r;
    assign err_cnt_o  = err_cnt_r;
    assign cfg_v_o    = cfg_v_r;
    assign cfg_w_v_o  = req_r.w_v;
    assign cfg_core_o = req_r.core;
    assign cfg_addr_o = req_r.addr;
    assign cfg_data_o = req_r.data;

endmodule

// File: tb/tb_bp_cfg_bus_loader.sv
// Self-checking bench for bp_cfg_bus_loader: a transaction-list model of the
// expected bus traffic, a responder with random latency, and directed plus
// random sequences.

module tb_bp_cfg_bus_loader;

    localparam int NC = 4;
    localparam int NE = 2;
    localparam int CW = 8;
    localparam int AW = 16;
    localparam int DW = 64;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          start_i;
    logic          verify_i;
    logic [NC-1:0] core_mask_i;
    logic [NE*AW-1:0] table_addr_i;
    logic [NE*DW-1:0] table_data_i;
    logic          busy_o, done_o, err_o;
    logic [7:0]    err_cnt_o;
    logic          cfg_v_o, cfg_w_v_o;
    logic [CW-1:0] cfg_core_o;
    logic [AW-1:0] cfg_addr_o;
    logic [DW-1:0] cfg_data_o;
    logic          cfg_ready_i;
    logic          cfg_resp_v_i;
    logic [DW-1:0] cfg_resp_data_i;

    typedef struct {
        logic          wv;
        logic [CW-1:0] core;
        int            entry;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          expQ[$];
    logic [AW-1:0] tblAddr[NE];
    logic [DW-1:0] tblData[NE];
    int            checkCount = 0;
    int            passCount  = 0;

    bp_cfg_bus_loader #(
        .num_core_p       (NC),
        .num_entries_p    (NE),
        .cfg_core_width_p (CW),
        .cfg_addr_width_p (AW),
        .cfg_data_width_p (DW)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .start_i         (start_i),
        .verify_i        (verify_i),
        .core_mask_i     (core_mask_i),
        .table_addr_i    (table_addr_i),
        .table_data_i    (table_data_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .err_cnt_o       (err_cnt_o),
        .cfg_v_o         (cfg_v_o),
        .cfg_w_v_o       (cfg_w_v_o),
        .cfg_core_o      (cfg_core_o),
        .cfg_addr_o      (cfg_addr_o),
        .cfg_data_o      (cfg_data_o),
        .cfg_ready_i     (cfg_ready_i),
        .cfg_resp_v_i    (cfg_resp_v_i),
        .cfg_resp_data_i (cfg_resp_data_i)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    // Runs one start-to-done sequence. bpMode: 0 ready high, 1 random ready,
    // 2 ready low on cycles 2..4. corrupt bit (core*NE+entry) flips bit 0 of that
    // read response. abortAtRead>0 pulls reset while waiting on that read's response.
    task automatic applyStimulus(input logic [NC-1:0] mask, input logic verify, input int bpMode,
                                 input logic inject, input logic [NC*NE-1:0] corrupt, input int abortAtRead);
        int          cycle = 0;
        int          expErr = 0;
        int          errSoFar = 0;
        int          nSel;
        int          doneCycle = 0;
        int          readCount = 0;
        int          respDelay = 0;
        logic        doneSeen = 1'b0;
        logic        respPending = 1'b0;
        logic        abortNow = 1'b0;
        logic        respBad = 1'b0;
        logic        rdy;
        logic        have;
        logic        prevStall = 1'b0;
        logic [89:0] prevPayload = '0;
        logic [DW-1:0] respData = '0;
        txn_t        exp;
        txn_t        t;

        for (int e = 0; e < NE; e++) begin
            tblAddr[e] = AW'($urandom);
            tblData[e] = {$urandom, $urandom};
            table_addr_i[e*AW +: AW] = tblAddr[e];
            table_data_i[e*DW +: DW] = tblData[e];
        end
        expQ.delete();
        for (int c = 0; c < NC; c++) begin
            if (mask[c]) begin
                for (int e = 0; e < NE; e++) begin
                    t.wv = 1'b1; t.core = CW'(c); t.entry = e; t.addr = tblAddr[e]; t.data = tblData[e];
                    expQ.push_back(t);
                    if (verify) begin
                        t.wv = 1'b0; t.data = '0;
                        expQ.push_back(t);
                        if (corrupt[c*NE+e]) expErr++;
                    end
                end
            end
        end
        nSel = $countones(mask);

        start_i = 1'b1; core_mask_i = mask; verify_i = verify;
        @(posedge clk_i); #1;
        start_i = 1'b0; core_mask_i = ~mask; verify_i = ~verify;
        cycle = 1;

        while (cycle <= 400 && !doneSeen) begin
            if (abortNow) begin
                checkOutput("err_pre_reset", err_o, errSoFar != 0);
                reset_n_i = 1'b0;
                cfg_ready_i = 1'b0; cfg_resp_v_i = 1'b0;
                #1;
                checkOutput("reset_outputs",
                    {busy_o, done_o, err_o, err_cnt_o, cfg_v_o, cfg_w_v_o, cfg_core_o, cfg_addr_o, cfg_data_o}, '0);
                #2 reset_n_i = 1'b1;
                @(posedge clk_i); #1;
                return;
            end
            cfg_resp_v_i = 1'b0; cfg_resp_data_i = '0; start_i = 1'b0;
            if (cycle == 1) begin
                checkOutput("first_req", cfg_v_o, mask != 0);
                checkOutput("start_clears_err", {err_o, err_cnt_o}, '0);
            end
            checkOutput("busy", busy_o, 1'b1);
            if (prevStall)
                checkOutput("stall_hold", {cfg_v_o, cfg_w_v_o, cfg_core_o, cfg_addr_o, cfg_data_o}, prevPayload);
            if (respPending) begin
                if (respDelay <= 1) begin
                    cfg_resp_v_i = 1'b1; cfg_resp_data_i = respData;
                    respPending = 1'b0;
                    if (respBad) errSoFar++;
                end else begin
                    respDelay--;
                end
            end
            if (inject && cycle == 2) begin
                start_i = 1'b1; core_mask_i = '1; verify_i = 1'b1;
            end
            if (inject && cycle == 3 && !verify && !respPending) begin
                cfg_resp_v_i = 1'b1; cfg_resp_data_i = {$urandom, $urandom};
            end
            case (bpMode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = !(cycle >= 2 && cycle <= 4);
                default: rdy = 1'b1;
            endcase
            cfg_ready_i = rdy;
            if (cfg_v_o && rdy) begin
                have = expQ.size() > 0;
                checkOutput("req_expected", have, 1'b1);
                if (have) begin
                    exp = expQ.pop_front();
                    checkOutput("req", {cfg_w_v_o, cfg_core_o, cfg_addr_o, cfg_data_o},
                                {exp.wv, exp.core, exp.addr, exp.data});
                    if (!exp.wv) begin
                        readCount++;
                        respPending = 1'b1;
                        respDelay = $urandom_range(1, 3);
                        respBad = corrupt[int'(exp.core)*NE + exp.entry];
                        respData = tblData[exp.entry] ^ DW'(respBad);
                        if (readCount == abortAtRead) abortNow = 1'b1;
                    end
                end
            end
            prevStall = cfg_v_o && !rdy;
            prevPayload = {cfg_v_o, cfg_w_v_o, cfg_core_o, cfg_addr_o, cfg_data_o};
            if (done_o) begin
                doneSeen = 1'b1;
                doneCycle = cycle;
            end else begin
                @(posedge clk_i); #1;
                cycle++;
            end
        end

        cfg_ready_i = 1'b0; cfg_resp_v_i = 1'b0; start_i = 1'b0;
        checkOutput("done_seen", doneSeen, 1'b1);
        checkOutput("all_reqs_issued", expQ.size(), 0);
        if (!verify && bpMode == 0)
            checkOutput("done_cycle", doneCycle, nSel*NE + 1);
        checkOutput("err_status", {err_o, err_cnt_o}, {expErr != 0, 8'(expErr)});
        @(posedge clk_i); #1;
        checkOutput("idle_after", {busy_o, done_o, cfg_v_o}, '0);
    endtask

    // Directed scenarios followed by randomized sequences.
    initial begin
        reset_n_i = 1'b0; start_i = 1'b0; verify_i = 1'b0; core_mask_i = '0;
        table_addr_i = '0; table_data_i = '0;
        cfg_ready_i = 1'b0; cfg_resp_v_i = 1'b0; cfg_resp_data_i = '0;
        #12;
        checkOutput("reset_state",
            {busy_o, done_o, err_o, err_cnt_o, cfg_v_o, cfg_w_v_o, cfg_core_o, cfg_addr_o, cfg_data_o}, '0);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        $display("[TB] write-only mask 1010");
        applyStimulus(4'b1010, 1'b0, 0, 1'b0, '0, 0);
        $display("[TB] stray response and start mid-sequence");
        applyStimulus(4'b1010, 1'b0, 0, 1'b1, '0, 0);
        $display("[TB] backpressure");
        applyStimulus(4'b0111, 1'b0, 2, 1'b0, '0, 0);
        $display("[TB] verify with corrupted entry1");
        applyStimulus(4'b0001, 1'b1, 0, 1'b0, 8'b0000_0010, 0);
        applyStimulus(4'b0001, 1'b1, 1, 1'b0, '0, 0);
        $display("[TB] empty mask");
        applyStimulus(4'b0000, 1'b0, 0, 1'b0, '0, 0);
        $display("[TB] reset during response wait");
        applyStimulus(4'b0011, 1'b1, 0, 1'b0, 8'b0000_0001, 2);
        applyStimulus(4'b0011, 1'b1, 1, 1'b0, '0, 0);
        $display("[TB] random sequences");
        for (int r = 0; r < 8; r++) begin
            applyStimulus(NC'($urandom), 1'($urandom), int'($urandom_range(0, 1)), 1'b0,
                          (NC*NE)'($urandom), 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
